// File: rtl/sys_bridge_n_pkg.sv
// Shared constants for the CPU-to-peripheral bridge: default window map, device indices, HWInt bit positions.
// Also holds the registered read-response bundle and the window base helper.
package sys_bridge_n_pkg;

    localparam logic [31:0] DEF_BASE_ADDR  = 32'h0000_7F00;
    localparam logic [31:0] DEF_DEV_STRIDE = 32'h0000_0010;

    localparam int DEV_TIMER0 = 0;
    localparam int DEV_TIMER1 = 1;
    localparam int DEV_UART   = 2;
    localparam int DEV_GPIO   = 3;

    // hw_int[k] lands on CP0 HWInt[k+2]
    localparam int HWINT_LSB    = 2;
    localparam int HWINT_TIMER0 = 2;
    localparam int HWINT_TIMER1 = 3;
    localparam int HWINT_UART   = 4;
    localparam int HWINT_GPIO   = 5;

    typedef struct packed {
        logic [31:0] dat;
        logic        vld;
        logic        err;
    } rd_rsp_t;

    function automatic logic [31:0] win_base(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input int          idx);
        return base + stride * 32'(idx);
    endfunction

endpackage

// File: rtl/sys_bridge_n_irq_sync.sv
// One interrupt line: synchroniser, rising-edge detect, pending latch with ack, level/edge select.
// Latency: SYNC_STAGES+1 cycles (level) or SYNC_STAGES+2 cycles (edge); no backpressure.
module sys_bridge_n_irq_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_in,
    input  logic irq_ack,
    output logic hw_int
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d_q;
    logic                   pend_q;
    logic                   pend_d;
    logic                   hw_int_q;
    logic                   hw_int_d;

    assign s = sync_q[SYNC_STAGES-1];

    // A fresh edge beats a simultaneous ack so no interrupt is lost.
    always_comb begin
        pend_d   = (pend_q & ~irq_ack) | (s & ~s_d_q);
        hw_int_d = EDGE_MODE ? pend_q : s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            s_d_q    <= 1'b0;
            pend_q   <= 1'b0;
            hw_int_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], irq_in};
            s_d_q    <= s;
            pend_q   <= pend_d;
            hw_int_q <= hw_int_d;
        end
    end

    assign hw_int = hw_int_q;

endmodule

// File: rtl/sys_bridge_n.sv
// Bridge from the CPU data port to NUM_DEV address windows, plus interrupt synchronisation to CP0.
// Latency: writes strobe combinationally, reads/errors respond exactly 1 cycle later; no backpressure.
module sys_bridge_n
    import sys_bridge_n_pkg::*;
#(
    parameter int                   NUM_DEV     = 4,
    parameter logic [31:0]          BASE_ADDR   = DEF_BASE_ADDR,
    parameter logic [31:0]          DEV_STRIDE  = DEF_DEV_STRIDE,
    parameter int                   DEV_WORDS   = 3,
    parameter int                   NUM_IRQ     = 6,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0]   IRQ_EDGE    = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             pr_addr,
    input  logic [31:0]             pr_wd,
    input  logic                    pr_we,
    input  logic                    pr_re,
    output logic [31:0]             pr_rd,
    output logic                    pr_rd_valid,
    output logic                    pr_err,
    output logic [1:0]              dev_addr,
    output logic [31:0]             dev_wd,
    output logic [NUM_DEV-1:0]      dev_we,
    input  logic [32*NUM_DEV-1:0]   dev_rd,
    input  logic [NUM_IRQ-1:0]      irq_in,
    input  logic [NUM_IRQ-1:0]      irq_ack,
    output logic [NUM_IRQ-1:0]      hw_int
);

    logic [NUM_DEV-1:0]         hit;
    logic [NUM_DEV-1:0][31:0]   masked_rd;
    logic [31:0]                rd_mux;
    logic                       any_hit;
    logic                       wr_ok;
    logic                       rd_ok;
    logic                       acc_err;
    rd_rsp_t                    rsp_q;
    rd_rsp_t                    rsp_d;

    assign wr_ok = pr_we & ~pr_re;
    assign rd_ok = pr_re & ~pr_we;

    for (genvar i = 0; i < NUM_DEV; i++) begin : g_dev
        localparam logic [31:0] LO = win_base(BASE_ADDR, DEV_STRIDE, i);
        localparam logic [31:0] HI = LO + 32'(4 * DEV_WORDS - 1);

        assign hit[i]       = (pr_addr >= LO) && (pr_addr <= HI) && (pr_addr[1:0] == 2'b00);
        // Gated by reset_n so no device can be written while the bridge is held in reset.
        assign dev_we[i]    = reset_n & wr_ok & hit[i];
        assign masked_rd[i] = hit[i] ? dev_rd[32*i +: 32] : 32'h0;
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            rd_mux = rd_mux | masked_rd[i];
        end
    end

    assign any_hit  = |hit;
    assign acc_err  = (pr_re | pr_we) & (~any_hit | (pr_re & pr_we));
    assign dev_wd   = pr_wd;
    assign dev_addr = pr_addr[3:2];

    // A conflicting re+we access is not a read, so it reports pr_err only.
    always_comb begin
        rsp_d     = '0;
        rsp_d.dat = rsp_q.dat;
        if (rd_ok) begin
            rsp_d.vld = 1'b1;
            rsp_d.dat = any_hit ? rd_mux : 32'h0;
        end
        rsp_d.err = acc_err;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    assign pr_rd       = rsp_q.dat;
    assign pr_rd_valid = rsp_q.vld;
    assign pr_err      = rsp_q.err;

    for (genvar k = 0; k < NUM_IRQ; k++) begin : g_irq
        sys_bridge_n_irq_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (IRQ_EDGE[k])
        ) u_irq_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .irq_in  (irq_in[k]),
            .irq_ack (irq_ack[k]),
            .hw_int  (hw_int[k])
        );
    end

endmodule

// File: tb/tb_sys_bridge_n.sv
// Scoreboarded bench for sys_bridge_n: directed accesses, interrupt timing and reset behaviour.
module tb_sys_bridge_n;

    localparam logic [31:0] D0 = 32'hAABB_CCDD;
    localparam logic [31:0] D1 = 32'h1111_0001;
    localparam logic [31:0] D2 = 32'h2222_0002;
    localparam logic [31:0] D3 = 32'h4444_0003;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [31:0]  pr_addr;
    logic [31:0]  pr_wd;
    logic         pr_we;
    logic         pr_re;
    logic [31:0]  pr_rd;
    logic         pr_rd_valid;
    logic         pr_err;
    logic [1:0]   dev_addr;
    logic [31:0]  dev_wd;
    logic [3:0]   dev_we;
    logic [127:0] dev_rd;
    logic [5:0]   irq_in;
    logic [5:0]   irq_ack;
    logic [5:0]   hw_int;

    typedef struct {
        logic        vld;
        logic        err;
        logic [31:0] dat;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sys_bridge_n #(
        .NUM_DEV     (4),
        .BASE_ADDR   (32'h0000_7F00),
        .DEV_STRIDE  (32'h10),
        .DEV_WORDS   (3),
        .NUM_IRQ     (6),
        .SYNC_STAGES (2),
        .IRQ_EDGE    (6'b000010)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pr_addr     (pr_addr),
        .pr_wd       (pr_wd),
        .pr_we       (pr_we),
        .pr_re       (pr_re),
        .pr_rd       (pr_rd),
        .pr_rd_valid (pr_rd_valid),
        .pr_err      (pr_err),
        .dev_addr    (dev_addr),
        .dev_wd      (dev_wd),
        .dev_we      (dev_we),
        .dev_rd      (dev_rd),
        .irq_in      (irq_in),
        .irq_ack     (irq_ack),
        .hw_int      (hw_int)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && (pr_rd_valid || pr_err)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got vld=%b err=%b rd=%h at cycle %0d expected none",
                         pr_rd_valid, pr_err, pr_rd, cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(e.due));
                chk("rsp_vld", 32'(pr_rd_valid), 32'(e.vld));
                chk("rsp_err", 32'(pr_err), 32'(e.err));
                if (e.vld) chk("rsp_rd", pr_rd, e.dat);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one access for a cycle, optionally queues its response, checks the write strobe.
    task automatic do_acc(input logic we, input logic re, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_we,
                          input logic rsp, input logic vld, input logic err,
                          input logic [31:0] dat);
        exp_t e;
        step();
        pr_we   = we;
        pr_re   = re;
        pr_addr = addr;
        pr_wd   = wd;
        if (rsp) begin
            e.vld = vld;
            e.err = err;
            e.dat = dat;
            e.due = cyc + 1;
            sb.push_back(e);
        end
        #2;
        chk("dev_we", 32'(dev_we), 32'(exp_we));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            pr_we = 1'b0;
            pr_re = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected normal end");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        pr_addr = '0;
        pr_wd   = '0;
        pr_we   = 1'b0;
        pr_re   = 1'b0;
        dev_rd  = {D3, D2, D1, D0};
        irq_in  = '0;
        irq_ack = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pr_rd", pr_rd, 32'h0);
        chk("reset_valid", 32'(pr_rd_valid), 32'h0);
        chk("reset_err", 32'(pr_err), 32'h0);
        chk("reset_hw_int", 32'(hw_int), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic read and write
        do_acc(1'b0, 1'b1, 32'h7F04, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b0, D0);
        do_acc(1'b1, 1'b0, 32'h7F18, 32'h1234, 4'b0010, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("dev_addr", 32'(dev_addr), 32'h2);
        chk("dev_wd", dev_wd, 32'h1234);

        // Unmapped, misaligned and out-of-range accesses
        do_acc(1'b0, 1'b1, 32'h7F0C, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b1, 32'h0);
        do_acc(1'b0, 1'b1, 32'h7F02, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b1, 32'h0);
        do_acc(1'b0, 1'b1, 32'h8000, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b1, 32'h0);
        do_acc(1'b1, 1'b0, 32'h7F0C, 32'h55, 4'b0000, 1'b1, 1'b0, 1'b1, 32'h0);

        // Conflict, back-to-back reads, window edges
        do_acc(1'b1, 1'b1, 32'h7F00, 32'h77, 4'b0000, 1'b1, 1'b0, 1'b1, 32'h0);
        do_acc(1'b0, 1'b1, 32'h7F00, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b0, D0);
        do_acc(1'b0, 1'b1, 32'h7F10, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b0, D1);
        do_acc(1'b0, 1'b1, 32'h7F08, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b0, D0);
        do_acc(1'b0, 1'b1, 32'h7F3C, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b1, 32'h0);
        do_acc(1'b1, 1'b0, 32'h7F38, 32'h9, 4'b1000, 1'b0, 1'b0, 1'b0, 32'h0);
        do_acc(1'b0, 1'b1, 32'h7F38, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b0, D3);
        idle(3);
        chk("rd_hold_idle", pr_rd, D3);

        // Level line 0: 3-cycle delay in both directions
        irq_in[0] = 1'b1;
        step(); step();
        chk("lvl_rise_early", 32'(hw_int[0]), 32'h0);
        step();
        chk("lvl_rise", 32'(hw_int[0]), 32'h1);
        irq_in[0] = 1'b0;
        step(); step();
        chk("lvl_fall_early", 32'(hw_int[0]), 32'h1);
        step();
        chk("lvl_fall", 32'(hw_int[0]), 32'h0);

        // Edge line 1: 1-cycle pulse latches after 4 cycles
        irq_in[1] = 1'b1;
        step();
        irq_in[1] = 1'b0;
        step(); step();
        chk("edge_rise_early", 32'(hw_int[1]), 32'h0);
        step();
        chk("edge_rise", 32'(hw_int[1]), 32'h1);
        repeat (4) step();
        chk("edge_hold", 32'(hw_int[1]), 32'h1);
        irq_ack[1] = 1'b1;
        step();
        irq_ack[1] = 1'b0;
        step();
        chk("edge_ack_clear", 32'(hw_int[1]), 32'h0);

        // Ack coinciding with a new rising edge: set wins
        irq_in[1] = 1'b1;
        step();
        irq_in[1] = 1'b0;
        step();
        irq_ack[1] = 1'b1;
        step();
        irq_ack[1] = 1'b0;
        step();
        chk("edge_set_wins", 32'(hw_int[1]), 32'h1);
        step();
        chk("edge_set_hold", 32'(hw_int[1]), 32'h1);

        // Reset mid-read and mid-interrupt
        irq_in[0] = 1'b1;
        repeat (4) step();
        chk("pre_reset_hw_int", 32'(hw_int), 32'h3);
        do_acc(1'b0, 1'b1, 32'h7F00, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_pr_rd", pr_rd, 32'h0);
        chk("arst_valid", 32'(pr_rd_valid), 32'h0);
        chk("arst_err", 32'(pr_err), 32'h0);
        chk("arst_hw_int", 32'(hw_int), 32'h0);
        pr_we = 1'b1;
        pr_re = 1'b0;
        #1;
        chk("arst_dev_we", 32'(dev_we), 32'h0);
        pr_we  = 1'b0;
        irq_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_valid", 32'(pr_rd_valid), 32'h0);
            chk("post_rst_hw_int", 32'(hw_int), 32'h0);
        end

        do_acc(1'b0, 1'b1, 32'h7F10, 32'h0, 4'b0000, 1'b1, 1'b1, 1'b0, D1);
        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
